// File: rtl/snn_spi_cfg_ctrl.sv
// SPI-slave config controller for the 3-input SNN core.
// Deframes 16-bit writes into the weight/threshold/leak/control bank.
module snn_spi_cfg_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                NUM_W    = 9,
  parameter logic [DATA_W-1:0] THR_RST  = 8'd16,
  parameter logic [DATA_W-1:0] LEAK_RST = 8'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_sck,
  input  logic                      spi_cs_n,
  input  logic                      spi_copi,
  output logic [NUM_W*DATA_W-1:0]   weights,
  output logic [DATA_W-1:0]         threshold,
  output logic [DATA_W-1:0]         leak,
  output logic                      snn_en,
  output logic                      cfg_stall,
  output logic                      cfg_update,
  output logic                      frame_err
);

  localparam int WB = NUM_W * DATA_W;

  typedef enum logic [1:0] {
    IDLE, SHIFT, COMMIT, ERR
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sck_q, sck_d;
  logic [2:0]        cs_q, cs_d;
  logic [1:0]        copi_q, copi_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]       shift_q, shift_d;
  logic              pend_q, pend_d;
  logic [WB-1:0]     weights_q, weights_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [DATA_W-1:0] leak_q, leak_d;
  logic              en_q, en_d;
  logic              stall_q, stall_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;

  logic              sck_rise;
  logic              cs_fall;
  logic              cs_rise;
  logic              w_bit;
  logic [6:0]        addr;
  logic [DATA_W-1:0] data;
  logic              addr_ok;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign w_bit    = shift_q[15];
  assign addr     = shift_q[14:8];
  assign data     = shift_q[DATA_W-1:0];
  assign addr_ok  = addr < 7'(NUM_W + 3);

  always_comb begin
    sck_d     = {sck_q[1:0], spi_sck};
    cs_d      = {cs_q[1:0], spi_cs_n};
    copi_d    = {copi_q[0], spi_copi};
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pend_d    = pend_q;
    weights_d = weights_q;
    thr_d     = thr_q;
    leak_d    = leak_q;
    en_d      = en_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // a select that fell during COMMIT/ERR is still honoured here
        if (cs_fall || (pend_q && !cs_q[1])) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
          pend_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = (bit_cnt_q == 5'd16) ? COMMIT : ERR;
        end else if (sck_rise) begin
          shift_d = {shift_q[14:0], copi_q[1]};
          if (bit_cnt_q != 5'd17) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        pend_d  = cs_fall;
        if (w_bit) begin
          if (addr_ok) begin
            upd_d = 1'b1;
            for (int i = 0; i < NUM_W; i++) begin
              if (addr == 7'(i)) begin
                weights_d[i*DATA_W +: DATA_W] = data;
              end
            end
            if (addr == 7'(NUM_W))     thr_d  = data;
            if (addr == 7'(NUM_W + 1)) leak_d = data;
            if (addr == 7'(NUM_W + 2)) en_d   = shift_q[0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ERR: begin
        state_d = IDLE;
        pend_d  = cs_fall;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q     <= 3'b000;
      cs_q      <= 3'b111;
      copi_q    <= 2'b00;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pend_q    <= 1'b0;
      weights_q <= '0;
      thr_q     <= THR_RST;
      leak_q    <= LEAK_RST;
      en_q      <= 1'b0;
      stall_q   <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      copi_q    <= copi_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pend_q    <= pend_d;
      weights_q <= weights_d;
      thr_q     <= thr_d;
      leak_q    <= leak_d;
      en_q      <= en_d;
      stall_q   <= stall_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
    end
  end

  assign weights    = weights_q;
  assign threshold  = thr_q;
  assign leak       = leak_q;
  assign snn_en     = en_q;
  assign cfg_stall  = stall_q;
  assign cfg_update = upd_q;
  assign frame_err  = err_q;

endmodule
